apb3_slave_regbank: RTL
=======================

Name: apb3_slave_regbank

Overview:
Parametrised APB3 register-bank slave, the next generation of the SoC's simple APB3 slave wrapper. It sits on the SoC APB3 peripheral bus and provides:
- a control register driving user logic
- a read-only status register
- an interrupt block with pending and enable registers
- NUM_REG general-purpose registers
- configurable wait states and PSLVERROR reporting for bad accesses.

Parameters:
ADDR_WIDTH, 12, width of PADDR.
DATA_WIDTH, 32, register and data-bus width.
NUM_REG, 8, number of general-purpose registers; legal range 1..(2**(ADDR_WIDTH-2))-4.
NUM_IRQ, 8, number of interrupt sources; must be <= DATA_WIDTH.
WAIT_STATES, 0, PREADY-low cycles inserted per access; legal range 0..15.

Ports:
clk  in  1  bus and logic clock
resetn  in  1  synchronous active-low reset
PADDR  in  ADDR_WIDTH  APB3 address (byte address)
PSEL  in  1  APB3 select
PENABLE  in  1  APB3 enable
PWRITE  in  1  APB3 direction, 1 = write
PWDATA  in  DATA_WIDTH  APB3 write data
PREADY  out  1  APB3 ready
PRDATA  out  DATA_WIDTH  APB3 read data
PSLVERROR  out  1  APB3 slave error
ctrl_out  out  DATA_WIDTH  contents of CTRL register
status_in  in  DATA_WIDTH  hardware status, read through STATUS register
gp_out  out  NUM_REG*DATA_WIDTH  GP registers flattened; GP[k] at bits [k*DATA_WIDTH +: DATA_WIDTH]
irq_src  in  NUM_IRQ  synchronous interrupt sources, rising-edge sensitive
irq_out  out  1  registered interrupt to CPU

Behaviour:
- Clock and reset: single clock clk. resetn is synchronous and active-low, sampled only at posedge clk.
- Reset values: state=IDLE; cnt=0; CTRL, IRQ_PENDING, IRQ_ENABLE and all GP registers = 0; irq_src edge-detect register = 0; irq_out=0.
- Register map (byte offsets, word aligned):
  - 0x00 CTRL: read/write.
  - 0x04 STATUS: read-only, returns status_in sampled combinationally.
  - 0x08 IRQ_PENDING: write-1-to-clear, bits [NUM_IRQ-1:0].
  - 0x0C IRQ_ENABLE: read/write, bits [NUM_IRQ-1:0].
  - 0x10+4k GP[k]: read/write, for k < NUM_REG.
  - Unimplemented bits read 0.
- Error accesses: PADDR[1:0]!=0, offset >= 0x10+4*NUM_REG, or a write to STATUS.
  - Completes normally with the same wait states.
  - PSLVERROR=1, PRDATA=0, no register side effects.
- FSM states IDLE, SETUP, ACCESS:
  - IDLE: PSEL&!PENABLE -> SETUP. PSEL&PENABLE in IDLE is a protocol violation: PREADY=1 and PSLVERROR=1 in that cycle, no side effects, stay IDLE.
  - SETUP: !PSEL or !PENABLE -> IDLE. Otherwise this is the first access cycle: if PREADY -> IDLE, else -> ACCESS with cnt<=1.
  - ACCESS: !PSEL -> IDLE with cnt<=0 (abort, no commit). PREADY -> IDLE with cnt<=0. Otherwise cnt<=cnt+1.
- Handshake:
  - access_cyc = PSEL & PENABLE & (state==SETUP | state==ACCESS).
  - PREADY = access_cyc & (cnt==WAIT_STATES); combinational from registered state.
  - Access latency = WAIT_STATES+1 cycles from PENABLE rise; zero wait states when WAIT_STATES=0.
  - PRDATA and PSLVERROR are valid only while PREADY=1; PRDATA=0 at all other times.
  - Writes commit at the posedge that ends the PREADY=1 cycle; GP writes become visible on gp_out the following cycle.
- Interrupts:
  - rise[i] = irq_src[i] & !irq_src_q[i].
  - pending[i] <= rise[i] | (pending[i] & !(w1c_write & PWDATA[i])). Simultaneous rise and clear: set wins.
  - irq_out <= |(pending & enable); one cycle latency.
  - Writing IRQ_ENABLE does not alter pending.
- Reset mid-transfer: FSM returns to IDLE; the in-flight write is discarded.

Decomposition:
- Shared package apb3_regbank_pkg holds:
  - register offsets (OFS_CTRL, OFS_STATUS, OFS_IRQ_PEND, OFS_IRQ_EN, OFS_GP_BASE)
  - FSM state encodings (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10)
  - WAIT_STATES counter width (4).
- One sub-module, apb3_irq_ctrl (NUM_IRQ), owns:
  - edge detect
  - pending/enable registers
  - W1C logic
  - irq_out register.

Test Plan:
- Reset, then read every offset 0x00..0x2C with WAIT_STATES=0 -> PREADY on first access cycle; PRDATA=0 except STATUS returns status_in=0xA5A5_0001.
- Write GP[3] (0x1C) = 0xDEADBEEF, read back -> PRDATA=0xDEADBEEF; gp_out[127:96]=0xDEADBEEF from the cycle after commit.
- WAIT_STATES=3: write CTRL=0x7 -> PREADY low for 3 access cycles, high on the 4th; ctrl_out=0x7 only after the 4th cycle. Drop PSEL in cycle 2 of a second write -> ctrl_out unchanged.
- Read 0x30 with NUM_REG=8, read 0x02, write 0x04 -> each returns PSLVERROR=1, PRDATA=0; no register changes.
- IRQ_ENABLE=0x1, pulse irq_src[0] -> IRQ_PENDING=0x1, irq_out=1 one cycle later. Write 0x1 to 0x08 in the same cycle as a new irq_src[0] rise -> pending stays 1. Clear with no edge -> irq_out=0 next cycle.
- PSEL&PENABLE asserted from IDLE -> PREADY=1 and PSLVERROR=1 in that cycle. Assert resetn=0 mid-ACCESS -> FSM in IDLE next cycle, all registers 0.

Source files
------------

// File: rtl/apb3_regbank_pkg.sv
// apb3_regbank_pkg: shared definitions for the APB3 register bank.
// Register offsets, FSM encoding, wait counter width, decode bundle.
package apb3_regbank_pkg;

    localparam int OFS_CTRL     = 'h00;
    localparam int OFS_STATUS   = 'h04;
    localparam int OFS_IRQ_PEND = 'h08;
    localparam int OFS_IRQ_EN   = 'h0C;
    localparam int OFS_GP_BASE  = 'h10;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

    typedef struct packed {
        logic ctrl;
        logic status;
        logic pend;
        logic en;
        logic gp;
        logic err;
    } dec_t;

endpackage

// File: rtl/apb3_slave_regbank_irq.sv
// apb3_irq_ctrl: rising-edge interrupt capture with W1C pending,
// enable mask and registered irq_out.
// Ports: clk, resetn (sync, active-low), irq_src, en_we/w1c_we
// strobes with wdata, pending/enable readback, irq_out.
module apb3_irq_ctrl #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic               en_we,
    input  logic               w1c_we,
    input  logic [NUM_IRQ-1:0] wdata,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] enable,
    output logic               irq_out
);

    logic [NUM_IRQ-1:0] src_q;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clr;

    assign rise = irq_src & ~src_q;
    assign clr  = w1c_we ? wdata : '0;

    // A new edge in the clearing cycle keeps the bit set.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            src_q   <= '0;
            pending <= '0;
            enable  <= '0;
            irq_out <= 1'b0;
        end else begin
            src_q   <= irq_src;
            pending <= rise | (pending & ~clr);
            if (en_we) enable <= wdata;
            irq_out <= |(pending & enable);
        end
    end

endmodule

// File: rtl/apb3_slave_regbank.sv
// apb3_slave_regbank: APB3 register-bank slave with CTRL, STATUS,
// IRQ pending/enable, NUM_REG GP registers and wait states.
// Ports: clk, resetn (sync, active-low); APB3 PADDR/PSEL/PENABLE/
// PWRITE/PWDATA/PREADY/PRDATA/PSLVERROR; ctrl_out, status_in,
// gp_out (flattened GP regs), irq_src, irq_out.
module apb3_slave_regbank
    import apb3_regbank_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REG     = 8,
    parameter int NUM_IRQ     = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
    output logic                           PREADY,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PSLVERROR,
    output logic [DATA_WIDTH-1:0]          ctrl_out,
    input  logic [DATA_WIDTH-1:0]          status_in,
    output logic [NUM_REG*DATA_WIDTH-1:0]  gp_out,
    input  logic [NUM_IRQ-1:0]             irq_src,
    output logic                           irq_out
);

    localparam int WW = ADDR_WIDTH - 2;

    localparam logic [WW-1:0] W_CTRL = WW'(OFS_CTRL / 4);
    localparam logic [WW-1:0] W_STAT = WW'(OFS_STATUS / 4);
    localparam logic [WW-1:0] W_PEND = WW'(OFS_IRQ_PEND / 4);
    localparam logic [WW-1:0] W_EN   = WW'(OFS_IRQ_EN / 4);
    localparam logic [WW:0]   W_GP   = (WW+1)'(OFS_GP_BASE / 4);
    // One bit wider: the end of the GP window may equal 2**WW.
    localparam logic [WW:0]   W_END  =
        (WW+1)'(OFS_GP_BASE / 4 + NUM_REG);

    localparam logic [CNT_W-1:0] WS = CNT_W'(WAIT_STATES);

    apb_state_e state_q;
    apb_state_e state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [WW-1:0] widx;
    logic [WW:0]   widx_x;
    dec_t          dec;

    logic access_cyc;
    logic ready_acc;
    logic viol;
    logic commit;

    logic [DATA_WIDTH-1:0] ctrl_q;
    logic [DATA_WIDTH-1:0] rdata;
    logic [NUM_REG-1:0][DATA_WIDTH-1:0] gp_q;

    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] enable;

    assign widx   = PADDR[ADDR_WIDTH-1:2];
    assign widx_x = {1'b0, widx};

    always_comb begin
        dec = '0;
        unique case (1'b1)
            (widx == W_CTRL): dec.ctrl   = 1'b1;
            (widx == W_STAT): dec.status = 1'b1;
            (widx == W_PEND): dec.pend   = 1'b1;
            (widx == W_EN):   dec.en     = 1'b1;
            (widx_x >= W_GP && widx_x < W_END):
                dec.gp = 1'b1;
            default: ;
        endcase
        dec.err = (PADDR[1:0] != 2'b00)
                | (widx_x >= W_END)
                | (PWRITE & dec.status);
    end

    assign access_cyc = PSEL & PENABLE
                      & (state_q == SETUP | state_q == ACCESS);
    assign ready_acc  = access_cyc & (cnt_q == WS);
    // PENABLE without a setup phase: answer at once, touch nothing.
    assign viol       = PSEL & PENABLE & (state_q == IDLE);
    assign commit     = ready_acc & PWRITE & ~dec.err;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) state_d = SETUP;
            end
            SETUP: begin
                if (!PSEL || !PENABLE) begin
                    state_d = IDLE;
                end else if (ready_acc) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACCESS;
                    cnt_d   = CNT_W'(1);
                end
            end
            ACCESS: begin
                if (!PSEL || ready_acc) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            dec.ctrl:   rdata = ctrl_q;
            dec.status: rdata = status_in;
            dec.pend:   rdata = DATA_WIDTH'(pending);
            dec.en:     rdata = DATA_WIDTH'(enable);
            dec.gp: begin
                for (int k = 0; k < NUM_REG; k++) begin
                    if (widx_x == W_GP + (WW+1)'(k))
                        rdata = gp_q[k];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        PREADY    = ready_acc | viol;
        PSLVERROR = viol | (ready_acc & dec.err);
        PRDATA    = '0;
        if (ready_acc && !PWRITE && !dec.err) PRDATA = rdata;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ctrl_q <= '0;
            gp_q   <= '0;
        end else if (commit) begin
            if (dec.ctrl) ctrl_q <= PWDATA;
            for (int k = 0; k < NUM_REG; k++) begin
                if (dec.gp && widx_x == W_GP + (WW+1)'(k))
                    gp_q[k] <= PWDATA;
            end
        end
    end

    assign ctrl_out = ctrl_q;
    assign gp_out   = gp_q;

    apb3_irq_ctrl #(
        .NUM_IRQ(NUM_IRQ)
    ) u_irq (
        .clk     (clk),
        .resetn  (resetn),
        .irq_src (irq_src),
        .en_we   (commit & dec.en),
        .w1c_we  (commit & dec.pend),
        .wdata   (PWDATA[NUM_IRQ-1:0]),
        .pending (pending),
        .enable  (enable),
        .irq_out (irq_out)
    );

endmodule
